// File: rtl/bm_mem_loader.sv
// Bitmatrix column store: packs host beats into BM_COL_W-bit columns, then serves
// 1-cycle-latency column reads to the bitmatrix memory controller.
module bm_mem_loader #(
    parameter int W         = 8,
    parameter int K_MAX     = 8,
    parameter int M_MAX     = 4,
    parameter int HOST_W    = 32,
    parameter int BM_COL_W  = W * W * K_MAX,
    parameter int BEATS     = BM_COL_W / HOST_W,
    parameter int BM_ADDR_W = $clog2(M_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M_MAX-1:0]     MReg,
    input  logic                 host_bm_load_start,
    input  logic [HOST_W-1:0]    host_bm_wr_data,
    input  logic                 host_bm_wr_val,
    output logic                 bm_mem_host_wr_rdy,
    output logic                 bm_mem_host_load_done,
    output logic                 bm_mem_host_err,
    output logic                 bm_mem_loaded,
    input  logic                 bm_cntl_bm_mem_rd_rq,
    input  logic [BM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
    output logic [BM_COL_W-1:0]  bm_mem_bm_cntl_rd_data,
    output logic                 bm_mem_bm_cntl_rd_data_val
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [M_MAX-1:0]  M_LIM     = M_MAX'(M_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic [M_MAX-1:0]    col_cnt, col_nxt;
    logic [M_MAX-1:0]    m_lat, m_lat_nxt;
    logic                done_nxt, start_err, mem_we, beat_acc, start_legal, rd_ok;
    logic [BM_COL_W-1:0] stage, col_merged;
    logic [BM_COL_W-1:0] mem [M_MAX];

    assign start_legal   = (MReg != '0) && (MReg <= M_LIM);
    assign beat_acc      = host_bm_wr_val && bm_mem_host_wr_rdy;
    assign bm_mem_loaded = (state == READY);
    assign rd_ok         = (state == READY) && (M_MAX'(bm_cntl_bm_mem_rd_addr) < m_lat);

    always_comb begin
        col_merged = stage;
        col_merged[beat_cnt*HOST_W +: HOST_W] = host_bm_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            col_cnt  <= '0;
            m_lat    <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            col_cnt  <= col_nxt;
            m_lat    <= m_lat_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        beat_nxt           = beat_cnt;
        col_nxt            = col_cnt;
        m_lat_nxt          = m_lat;
        done_nxt           = 1'b0;
        start_err          = 1'b0;
        mem_we             = 1'b0;
        bm_mem_host_wr_rdy = 1'b0;
        if (state == LOAD) begin
            bm_mem_host_wr_rdy = ~host_bm_load_start;
        end
        if (host_bm_load_start) begin
            // any start (from any state) either restarts at column 0 or is rejected
            if (start_legal) begin
                state_nxt = LOAD;
                m_lat_nxt = MReg;
                beat_nxt  = '0;
                col_nxt   = '0;
            end else begin
                start_err = 1'b1;
                if (state == LOAD) begin
                    state_nxt = IDLE;
                end
            end
        end else if (beat_acc) begin
            beat_nxt = beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
                mem_we   = 1'b1;
                beat_nxt = '0;
                col_nxt  = col_cnt + 1'b1;
                if (col_cnt == m_lat - 1'b1) begin
                    state_nxt = READY;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    // column store is deliberately not reset; bm_mem_loaded qualifies its contents
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            stage <= col_merged;
        end
        if (mem_we) begin
            mem[col_cnt[BM_ADDR_W-1:0]] <= col_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bm_mem_bm_cntl_rd_data     <= '0;
            bm_mem_bm_cntl_rd_data_val <= 1'b0;
            bm_mem_host_load_done      <= 1'b0;
            bm_mem_host_err            <= 1'b0;
        end else begin
            bm_mem_bm_cntl_rd_data_val <= 1'b0;
            bm_mem_host_load_done      <= done_nxt;
            bm_mem_host_err            <= start_err | (bm_cntl_bm_mem_rd_rq & ~rd_ok);
            if (bm_cntl_bm_mem_rd_rq) begin
                if (rd_ok) begin
                    bm_mem_bm_cntl_rd_data     <= mem[bm_cntl_bm_mem_rd_addr];
                    bm_mem_bm_cntl_rd_data_val <= 1'b1;
                end else begin
                    bm_mem_bm_cntl_rd_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_mem_loader.sv
// Scoreboard bench for bm_mem_loader: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever val, err or load_done appears.
module tb_bm_mem_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   mreg;
    logic         start;
    logic [31:0]  wdata;
    logic         wval;
    logic         rdy, load_done, err, loaded;
    logic         rd_rq;
    logic [1:0]   rd_addr;
    logic [511:0] rd_data;
    logic         rd_val;

    bm_mem_loader dut (
        .clk                        (clk),
        .rst                        (rst),
        .MReg                       (mreg),
        .host_bm_load_start         (start),
        .host_bm_wr_data            (wdata),
        .host_bm_wr_val             (wval),
        .bm_mem_host_wr_rdy         (rdy),
        .bm_mem_host_load_done      (load_done),
        .bm_mem_host_err            (err),
        .bm_mem_loaded              (loaded),
        .bm_cntl_bm_mem_rd_rq       (rd_rq),
        .bm_cntl_bm_mem_rd_addr     (rd_addr),
        .bm_mem_bm_cntl_rd_data     (rd_data),
        .bm_mem_bm_cntl_rd_data_val (rd_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         val;
        logic         err;
        logic         done;
        logic [511:0] data;
        bit           chk_data;
        int           tag;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           tag_n = 0;
    logic [511:0] exp_mem [4];
    int           m_model = 0;
    bit           ld_model = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (rd_val || err || load_done)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got val=%b err=%b done=%b, required none", rd_val, err, load_done);
            end else begin
                e = exp_q.pop_front();
                if (rd_val !== e.val || err !== e.err || load_done !== e.done ||
                    (e.chk_data && rd_data !== e.data)) begin
                    n_bad++;
                    $display("FAIL sb_event#%0d: got val=%b err=%b done=%b data=%h, required val=%b err=%b done=%b data=%h",
                             e.tag, rd_val, err, load_done, rd_data, e.val, e.err, e.done, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic v, input logic e, input logic d, input logic [511:0] data, input bit cd);
        exp_t x;
        x.val = v; x.err = e; x.done = d; x.data = data; x.chk_data = cd; x.tag = tag_n++;
        exp_q.push_back(x);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_rd_data"}, rd_data, 0);
        chk({nm, "_flags"}, {506'd0, rd_val, rdy, load_done, err, loaded}, 0);
    endtask

    task automatic send_beat(input logic [31:0] d);
        bit acc;
        acc   = 0;
        wval  = 1'b1;
        wdata = d;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = rdy;
            @(posedge clk);
            #1;
        end
        wval = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got no wr_rdy in 40 cycles, required accept of %h", d);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rdy_in_gap", rdy, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [3:0] m);
        mreg  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m >= 1 && m <= 4) begin
            m_model  = m;
            ld_model = 0;
        end else begin
            push(1'b0, 1'b1, 1'b0, 0, 0);
        end
    endtask

    task automatic send_column(input int c, input logic [31:0] base, input bit gaps);
        logic [511:0] col;
        logic [31:0]  d;
        col = '0;
        for (int b = 0; b < 16; b++) begin
            d = base + 32'(c * 16 + b);
            col[b*32 +: 32] = d;
            if (gaps) gap(int'($urandom_range(0, 2)));
            send_beat(d);
        end
        exp_mem[c] = col;
    endtask

    task automatic finish_load();
        push(1'b0, 1'b0, 1'b1, 0, 0);
        chk("load_done_pulse", load_done, 1);
        chk("loaded_level", loaded, 1);
        chk("rdy_in_ready", rdy, 0);
        ld_model = 1;
    endtask

    task automatic load_full(input logic [3:0] m, input logic [31:0] base, input bit gaps);
        start_load(m);
        for (int c = 0; c < int'(m); c++) send_column(c, base, gaps);
        finish_load();
    endtask

    task automatic do_read(input int a);
        rd_rq   = 1'b1;
        rd_addr = a[1:0];
        if (ld_model && a < m_model) push(1'b1, 1'b0, 1'b0, exp_mem[a], 1);
        else                         push(1'b0, 1'b1, 1'b0, 0, 1);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b0; start = 1'b0; wval = 1'b0; wdata = '0; mreg = '0; rd_rq = 1'b0; rd_addr = '0;
        // 1: reset, then an illegal read
        #2 rst = 1'b1;
        #2 chk_outputs_zero("reset");
        tick(); tick();
        rst = 1'b0;
        do_read(0);
        rd_rq = 1'b0;
        tick();

        // 2: two columns, data = global beat index
        load_full(2, 32'd0, 0);
        do_read(1);
        rd_rq = 1'b0;
        chk("t2_word0", rd_data[31:0], 16);
        chk("t2_word15", rd_data[511:480], 31);
        tick();

        // 3: four columns with random valid gaps, back-to-back reads
        load_full(4, 32'hA5A5_0000, 1);
        foreach (exp_mem[i]) ;
        do_read(3); chk("b2b_val0", rd_val, 1);
        do_read(0); chk("b2b_val1", rd_val, 1);
        do_read(2); chk("b2b_val2", rd_val, 1);
        do_read(1); chk("b2b_val3", rd_val, 1);
        rd_rq = 1'b0;
        tick();

        // 4: out-of-range read and illegal starts while READY
        load_full(3, 32'h3C00_0000, 0);
        do_read(3);
        rd_rq = 1'b0;
        tick();
        start_load(4'd0);
        tick();
        chk("t4_loaded_after_m0", loaded, 1);
        start_load(4'd5);
        tick();
        chk("t4_loaded_after_m5", loaded, 1);
        do_read(2);
        rd_rq = 1'b0;
        tick();

        // 5: restart mid-load; beat in start cycle must be dropped
        start_load(4);
        send_column(0, 32'h7700_0000, 0);
        for (int i = 0; i < 4; i++) send_beat(32'h7700_1000 + 32'(i));
        mreg  = 4'd1;
        start = 1'b1;
        wval  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_rdy_in_start", rdy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wval  = 1'b0;
        m_model  = 1;
        ld_model = 0;
        send_column(0, 32'h5500_0000, 0);
        finish_load();
        do_read(0);
        do_read(1);
        rd_rq = 1'b0;
        tick();

        // 6: reset during load discards the partial column
        start_load(2);
        for (int i = 0; i < 7; i++) send_beat(32'h1111_0000 + 32'(i));
        rst = 1'b1;
        #2 chk_outputs_zero("t6_reset");
        tick();
        rst = 1'b0;
        ld_model = 0;
        tick();
        load_full(1, 32'h6600_0000, 0);
        do_read(0);
        rd_rq = 1'b0;
        tick();

        repeat (5) tick();
        chk("queue_empty", 512'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
